// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Helpers work on a 64-bit word; callers narrow the result to DATA_W.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int unsigned CNT_W = 2;

  function automatic logic [7:0] lane_mask(input size_t size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] offset,
                                              input size_t size, input logic is_unsigned);
    logic [63:0] sh;
    logic [63:0] r;
    sh = word >> {offset, 3'b000};
    case (size)
      SZ_B:    r = {{56{~is_unsigned & sh[7]}}, sh[7:0]};
      SZ_H:    r = {{48{~is_unsigned & sh[15]}}, sh[15:0]};
      SZ_W:    r = {{32{~is_unsigned & sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_unit_bytemem.sv
// Byte-enabled data memory: per-lane write enables, registered read port.
module lsu_bytemem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit with internal byte-enabled memory, valid/ready request and
// response handshakes, alignment/range checking and configurable load latency.
module lsu_mem_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned LOAD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_imm,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_misalign,
  output logic              busy_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  size_t             l_size;
  logic              l_uns;
  logic [2:0]        l_off;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] widx;
  logic [2:0]        off;
  size_t             size;
  logic              misalign;
  logic              out_of_range;
  logic              accept;
  logic              mem_we;
  logic              mem_re;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_al;
  logic [DATA_W-1:0] rd_word;
  logic [63:0]       rd64;

  // req_ready is forced low during reset so a coincident store cannot commit.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy_o    = (state != ST_IDLE);

  always_comb begin
    addr          = req_base + req_imm;
    widx          = addr >> LB;
    off           = '0;
    off[LB-1:0]   = addr[LB-1:0];
    size          = size_t'(req_size);
    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = addr[0];
      SZ_W:    misalign = |addr[1:0];
      default: misalign = (DATA_W == 32) ? 1'b1 : |addr[2:0];
    endcase
    out_of_range  = (widx >= ADDR_W'(MEM_DEPTH));
    accept        = req_ready && req_valid;
    mem_we        = accept && req_store && !misalign && !out_of_range;
    mem_re        = accept && !req_store && !misalign && !out_of_range;
    be            = NB'(lane_mask(size, off));
    wdata_al      = req_wdata << {off, 3'b000};
    rd64          = '0;
    rd64[DATA_W-1:0] = rd_word;
  end

  lsu_bytemem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .be    (be),
    .idx   (widx[IDX_W-1:0]),
    .wdata (wdata_al),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      resp_misalign <= 1'b0;
      l_size        <= SZ_B;
      l_uns         <= 1'b0;
      l_off         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            l_size <= size;
            l_uns  <= req_unsigned;
            l_off  <= off;
            if (misalign || out_of_range) begin
              state         <= ST_RESP;
              resp_valid    <= 1'b1;
              resp_err      <= 1'b1;
              resp_misalign <= misalign;
              resp_rdata    <= '0;
            end else if (req_store) begin
              state         <= ST_RESP;
              resp_valid    <= 1'b1;
              resp_err      <= 1'b0;
              resp_misalign <= 1'b0;
              resp_rdata    <= '0;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state         <= ST_RESP;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            resp_rdata    <= DATA_W'(load_extend(rd64, l_off, l_size, l_uns));
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
